// File: rtl/jt10_adpcm_rom_arb.sv
// Shares one ADPCM sample-ROM read port between ADPCM-A and ADPCM-B (round-robin on ties, 1-byte B cache).
// ROM reads deliver ok 3+ cycles after the request, B cache hits 1 cycle after; rom_cs is held until rom_ok.
module jt10_adpcm_rom_arb #(
  parameter int AW = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic [AW-1:0] a_addr,
  output logic [7:0]    a_data,
  output logic          a_ok,
  input  logic          b_req,
  input  logic [AW-1:0] b_addr,
  input  logic          b_flush,
  output logic [7:0]    b_data,
  output logic          b_ok,
  output logic          rom_cs,
  output logic [AW-1:0] rom_addr,
  input  logic [7:0]    rom_data,
  input  logic          rom_ok
);

  typedef enum logic [1:0] {IDLE, A_RD, B_RD} state_t;

  state_t        state_q, state_d;
  logic          rom_cs_q, rom_cs_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic          a_ok_q, a_ok_d, b_ok_q, b_ok_d;
  logic [7:0]    a_data_q, a_data_d, b_data_q, b_data_d;
  logic          cache_vld_q, cache_vld_d;
  logic [AW-1:0] cache_addr_q, cache_addr_d;
  logic [7:0]    cache_data_q, cache_data_d;
  logic          last_b_q, last_b_d;
  logic          a_srv_q, a_srv_d, b_srv_q, b_srv_d;

  logic a_pend, b_pend, b_hit, b_miss;

  // The ok cycle itself is excluded so a held request is not served twice before srv registers.
  assign a_pend = a_req & ~a_srv_q & ~a_ok_q;
  assign b_pend = b_req & ~b_srv_q & ~b_ok_q;
  assign b_hit  = b_pend & cache_vld_q & ~b_flush & (cache_addr_q == b_addr);
  assign b_miss = b_pend & ~b_hit;

  always_comb begin
    state_d      = state_q;
    rom_cs_d     = rom_cs_q;
    rom_addr_d   = rom_addr_q;
    a_ok_d       = 1'b0;
    b_ok_d       = 1'b0;
    a_data_d     = a_data_q;
    b_data_d     = b_data_q;
    cache_vld_d  = cache_vld_q & ~b_flush;
    cache_addr_d = cache_addr_q;
    cache_data_d = cache_data_q;
    last_b_d     = last_b_q;
    a_srv_d      = a_req & (a_srv_q | a_ok_q);
    b_srv_d      = b_req & (b_srv_q | b_ok_q);

    case (state_q)
      IDLE: begin
        if (b_hit) begin
          b_data_d = cache_data_q;
          b_ok_d   = 1'b1;
        end
        // On a tie with a B miss, A wins only if B was granted last.
        if (a_pend && (!b_miss || last_b_q)) begin
          rom_addr_d = a_addr;
          rom_cs_d   = 1'b1;
          last_b_d   = 1'b0;
          state_d    = A_RD;
        end else if (b_miss) begin
          rom_addr_d = b_addr;
          rom_cs_d   = 1'b1;
          last_b_d   = 1'b1;
          state_d    = B_RD;
        end
      end
      A_RD: begin
        if (rom_ok) begin
          a_data_d = rom_data;
          a_ok_d   = 1'b1;
          rom_cs_d = 1'b0;
          state_d  = IDLE;
        end
      end
      B_RD: begin
        if (rom_ok) begin
          b_data_d = rom_data;
          b_ok_d   = 1'b1;
          rom_cs_d = 1'b0;
          state_d  = IDLE;
          if (!b_flush) begin
            cache_vld_d  = 1'b1;
            cache_addr_d = rom_addr_q;
            cache_data_d = rom_data;
          end
        end
      end
      default: begin
        rom_cs_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rom_cs_q     <= 1'b0;
      rom_addr_q   <= '0;
      a_ok_q       <= 1'b0;
      b_ok_q       <= 1'b0;
      a_data_q     <= 8'h00;
      b_data_q     <= 8'h00;
      cache_vld_q  <= 1'b0;
      cache_addr_q <= '0;
      cache_data_q <= 8'h00;
      last_b_q     <= 1'b1;
      a_srv_q      <= 1'b0;
      b_srv_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      rom_cs_q     <= rom_cs_d;
      rom_addr_q   <= rom_addr_d;
      a_ok_q       <= a_ok_d;
      b_ok_q       <= b_ok_d;
      a_data_q     <= a_data_d;
      b_data_q     <= b_data_d;
      cache_vld_q  <= cache_vld_d;
      cache_addr_q <= cache_addr_d;
      cache_data_q <= cache_data_d;
      last_b_q     <= last_b_d;
      a_srv_q      <= a_srv_d;
      b_srv_q      <= b_srv_d;
    end
  end

  assign rom_cs   = rom_cs_q;
  assign rom_addr = rom_addr_q;
  assign a_ok     = a_ok_q;
  assign b_ok     = b_ok_q;
  assign a_data   = a_data_q;
  assign b_data   = b_data_q;

endmodule

// File: tb/tb_jt10_adpcm_rom_arb.sv
// Directed and randomized bench for the ADPCM ROM arbiter, with a behavioural ROM responder.
module tb_jt10_adpcm_rom_arb;
  localparam int AW = 24;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_req, b_req, b_flush, rom_ok, a_ok, b_ok, rom_cs;
  logic [AW-1:0] a_addr, b_addr, rom_addr;
  logic [7:0]    a_data, b_data, rom_data;

  int checks = 0;
  int errors = 0;
  bit rom_auto = 1'b1;
  bit rom_rand = 1'b0;
  int rom_lat  = 2;
  bit rsp_busy = 1'b0;
  int rsp_cnt  = 0;
  int rsp_lat  = 1;

  jt10_adpcm_rom_arb #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_ok(a_ok),
    .b_req(b_req), .b_addr(b_addr), .b_flush(b_flush), .b_data(b_data), .b_ok(b_ok),
    .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_data(rom_data), .rom_ok(rom_ok)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_byte(input logic [AW-1:0] a);
    if (a == 24'h012345) return 8'h5A;
    if (a == 24'h000100) return 8'h3C;
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
  endfunction

  // ROM answers rsp_lat cycles after the first cycle it sees rom_cs.
  initial begin
    rom_ok   = 1'b0;
    rom_data = 8'h00;
    forever begin
      @(negedge clk);
      if (!rom_auto) rsp_busy = 1'b0;
      else begin
        rom_ok = 1'b0;
        if (rom_cs) begin
          if (!rsp_busy) begin
            rsp_busy = 1'b1;
            rsp_cnt  = 0;
            rsp_lat  = rom_rand ? int'($urandom_range(1, 8)) : rom_lat;
          end
          rsp_cnt++;
          if (rsp_cnt > rsp_lat) begin
            rom_ok   = 1'b1;
            rom_data = rom_byte(rom_addr);
            rsp_busy = 1'b0;
          end
        end else rsp_busy = 1'b0;
      end
    end
  end

  task automatic wait_ok(input bit want_b, input int limit, output int n,
                         output bit saw_cs, output logic [AW-1:0] cs_addr);
    n = -1; saw_cs = 1'b0; cs_addr = '0;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (rom_cs === 1'b1 && !saw_cs) begin saw_cs = 1'b1; cs_addr = rom_addr; end
      if ((want_b ? b_ok : a_ok) === 1'b1) begin n = i; break; end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; a_req = 1'b0; b_req = 1'b0; b_flush = 1'b0;
    a_addr = '0; b_addr = '0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (rom_cs !== 1'b0) begin errors++; $display("FAIL reset_rom_cs got=%b exp=0", rom_cs); end
    checks++; if (rom_addr !== 24'h0) begin errors++; $display("FAIL reset_rom_addr got=%h exp=000000", rom_addr); end
    checks++; if (a_ok !== 1'b0 || b_ok !== 1'b0) begin errors++; $display("FAIL reset_ok got=%b%b exp=00", a_ok, b_ok); end
    checks++; if (a_data !== 8'h00 || b_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h/%h exp=00/00", a_data, b_data); end
  endtask

  task automatic test_a_read();
    int n, oks, css; bit saw; logic [AW-1:0] ca;
    rom_lat = 2; a_addr = 24'h012345; a_req = 1'b1;
    wait_ok(1'b0, 40, n, saw, ca);
    checks++; if (ca !== 24'h012345) begin errors++; $display("FAIL a_rom_addr got=%h exp=012345", ca); end
    checks++; if (n !== 4) begin errors++; $display("FAIL a_latency got=%0d exp=4", n); end
    checks++; if (a_data !== 8'h5A) begin errors++; $display("FAIL a_data got=%h exp=5a", a_data); end
    oks = 0; css = 0;
    repeat (10) begin @(negedge clk); if (a_ok) oks++; if (rom_cs) css++; end
    checks++; if (oks !== 0 || css !== 0) begin errors++; $display("FAIL a_hold_refetch got ok=%0d cs=%0d exp 0/0", oks, css); end
    a_req = 1'b0; @(negedge clk);
    rom_lat = 1; a_addr = 24'h0000F0; a_req = 1'b1;
    wait_ok(1'b0, 40, n, saw, ca);
    checks++; if (n !== 3) begin errors++; $display("FAIL a_min_latency got=%0d exp=3", n); end
    checks++; if (a_data !== 8'h55) begin errors++; $display("FAIL a_min_data got=%h exp=55", a_data); end
    a_req = 1'b0; @(negedge clk);
    rom_lat = 2;
  endtask

  task automatic test_round_robin();
    int n; bit saw; logic [AW-1:0] ca;
    do_reset();
    for (int r = 0; r < 5; r++) begin
      logic [AW-1:0] g0, g1, e0, e1;
      int ng; bit ga, gb, prev;
      if (r == 4) begin
        a_addr = 24'h003000; a_req = 1'b1;
        wait_ok(1'b0, 40, n, saw, ca);
        a_req = 1'b0; @(negedge clk);
      end
      a_addr = 24'h001000 + AW'(r); b_addr = 24'h002000 + AW'(r);
      a_req = 1'b1; b_req = 1'b1;
      g0 = '0; g1 = '0; ng = 0; ga = 1'b0; gb = 1'b0; prev = 1'b0;
      for (int i = 0; i < 60 && !(ga && gb); i++) begin
        @(negedge clk);
        if (rom_cs && !prev) begin
          if (ng == 0) g0 = rom_addr; else g1 = rom_addr;
          ng++;
        end
        prev = rom_cs;
        if (a_ok) begin
          ga = 1'b1; a_req = 1'b0;
          checks++; if (a_data !== rom_byte(a_addr)) begin errors++; $display("FAIL rr_a_data r=%0d got=%h exp=%h", r, a_data, rom_byte(a_addr)); end
        end
        if (b_ok) begin
          gb = 1'b1; b_req = 1'b0;
          checks++; if (b_data !== rom_byte(b_addr)) begin errors++; $display("FAIL rr_b_data r=%0d got=%h exp=%h", r, b_data, rom_byte(b_addr)); end
        end
      end
      e0 = (r == 4) ? b_addr : a_addr;
      e1 = (r == 4) ? a_addr : b_addr;
      checks++; if (g0 !== e0 || g1 !== e1 || ng !== 2) begin errors++; $display("FAIL rr_order r=%0d got=%h,%h n=%0d exp=%h,%h n=2", r, g0, g1, ng, e0, e1); end
      a_req = 1'b0; b_req = 1'b0; @(negedge clk);
    end
  endtask

  task automatic test_cache_hit();
    int n; bit saw; logic [AW-1:0] ca;
    b_addr = 24'h000100; b_req = 1'b1;
    wait_ok(1'b1, 40, n, saw, ca);
    checks++; if (saw !== 1'b1 || b_data !== 8'h3C) begin errors++; $display("FAIL hit_fill got cs=%b data=%h exp cs=1 data=3c", saw, b_data); end
    b_req = 1'b0; @(negedge clk);
    b_req = 1'b1;
    wait_ok(1'b1, 10, n, saw, ca);
    checks++; if (n !== 1) begin errors++; $display("FAIL hit_latency got=%0d exp=1", n); end
    checks++; if (saw !== 1'b0 || b_data !== 8'h3C) begin errors++; $display("FAIL hit_data got cs=%b data=%h exp cs=0 data=3c", saw, b_data); end
    b_req = 1'b0; @(negedge clk);
  endtask

  task automatic test_flush();
    int n; bit saw; logic [AW-1:0] ca;
    b_flush = 1'b1; @(negedge clk); b_flush = 1'b0;
    b_addr = 24'h000100; b_req = 1'b1;
    wait_ok(1'b1, 40, n, saw, ca);
    checks++; if (saw !== 1'b1 || ca !== 24'h000100) begin errors++; $display("FAIL flush_miss got cs=%b addr=%h exp cs=1 addr=000100", saw, ca); end
    checks++; if (b_data !== 8'h3C) begin errors++; $display("FAIL flush_data got=%h exp=3c", b_data); end
    b_req = 1'b0; @(negedge clk);
  endtask

  task automatic test_flush_fill();
    int n; bit saw; logic [AW-1:0] ca;
    rom_auto = 1'b0; rom_ok = 1'b0;
    b_addr = 24'h000101; b_req = 1'b1;
    for (int i = 0; i < 10 && rom_cs !== 1'b1; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    rom_ok = 1'b1; rom_data = 8'h77; b_flush = 1'b1;
    @(negedge clk);
    rom_ok = 1'b0; b_flush = 1'b0;
    checks++; if (b_ok !== 1'b1 || b_data !== 8'h77) begin errors++; $display("FAIL flushfill_ok got ok=%b data=%h exp ok=1 data=77", b_ok, b_data); end
    b_req = 1'b0; @(negedge clk);
    rom_auto = 1'b1; b_req = 1'b1;
    wait_ok(1'b1, 40, n, saw, ca);
    checks++; if (saw !== 1'b1 || b_data !== 8'hA5) begin errors++; $display("FAIL flushfill_miss got cs=%b data=%h exp cs=1 data=a5", saw, b_data); end
    b_req = 1'b0; @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int bad;
    rom_auto = 1'b0; rom_ok = 1'b0;
    a_addr = 24'h000777; a_req = 1'b1;
    for (int i = 0; i < 10 && rom_cs !== 1'b1; i++) @(negedge clk);
    checks++; if (rom_cs !== 1'b1) begin errors++; $display("FAIL midrst_start got cs=%b exp=1", rom_cs); end
    rst_n = 1'b0; a_req = 1'b0;
    #1;
    checks++; if (rom_cs !== 1'b0 || rom_addr !== 24'h0) begin errors++; $display("FAIL midrst_async got cs=%b addr=%h exp 0/000000", rom_cs, rom_addr); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); rom_ok = 1'b1; rom_data = 8'h99;
    bad = 0;
    repeat (5) begin
      @(negedge clk); rom_ok = 1'b0;
      if (a_ok || b_ok || rom_cs) bad++;
    end
    checks++; if (bad !== 0 || a_data !== 8'h00) begin errors++; $display("FAIL midrst_late_ok got bad=%0d a_data=%h exp 0/00", bad, a_data); end
    rom_auto = 1'b1;
  endtask

  task automatic test_stress();
    bit a_out, b_out, prev_cs;
    int a_gap, b_gap, a_wait, b_wait, a_tx, b_tx, viol, spur, tmo, a_done, b_done;
    logic [AW-1:0] prev_addr;
    a_out = 0; b_out = 0; prev_cs = 0; a_gap = 0; b_gap = 0; a_wait = 0; b_wait = 0;
    a_tx = 0; b_tx = 0; viol = 0; spur = 0; tmo = 0; a_done = 0; b_done = 0; prev_addr = '0;
    rom_rand = 1'b1;
    for (int cyc = 0; cyc < 10400; cyc++) begin
      @(negedge clk);
      if (rom_cs && prev_cs && rom_addr !== prev_addr) viol++;
      if (rom_cs && !prev_cs) begin if (a_out) a_tx++; if (b_out) b_tx++; end
      prev_cs = rom_cs; prev_addr = rom_addr;
      b_flush = ($urandom_range(0, 31) == 0);
      if (a_out) begin
        if (a_ok) begin
          checks++;
          if (a_data !== rom_byte(a_addr) || a_tx > 2) begin
            errors++; $display("FAIL stress_a addr=%h got=%h exp=%h tx=%0d max=2", a_addr, a_data, rom_byte(a_addr), a_tx);
          end
          a_out = 0; a_req = 1'b0; a_gap = $urandom_range(1, 3); a_done++;
        end else if (++a_wait > 100) begin tmo++; a_out = 0; a_req = 1'b0; a_gap = 1; end
      end else begin
        if (a_ok) spur++;
        if (a_gap > 0) a_gap--;
        else if (cyc < 10000 && $urandom_range(0, 3) == 0) begin
          a_addr = AW'($urandom); a_req = 1'b1; a_out = 1; a_wait = 0; a_tx = 0;
        end
      end
      if (b_out) begin
        if (b_ok) begin
          checks++;
          if (b_data !== rom_byte(b_addr) || b_tx > 2) begin
            errors++; $display("FAIL stress_b addr=%h got=%h exp=%h tx=%0d max=2", b_addr, b_data, rom_byte(b_addr), b_tx);
          end
          b_out = 0; b_req = 1'b0; b_gap = $urandom_range(1, 3); b_done++;
        end else if (++b_wait > 100) begin tmo++; b_out = 0; b_req = 1'b0; b_gap = 1; end
      end else begin
        if (b_ok) spur++;
        if (b_gap > 0) b_gap--;
        else if (cyc < 10000 && $urandom_range(0, 3) == 0) begin
          b_addr = ($urandom_range(0, 3) == 0) ? AW'($urandom) : 24'h000100 + AW'($urandom_range(0, 3));
          b_req = 1'b1; b_out = 1; b_wait = 0; b_tx = 0;
        end
      end
    end
    b_flush = 1'b0; a_req = 1'b0; b_req = 1'b0; rom_rand = 1'b0;
    checks++; if (viol !== 0) begin errors++; $display("FAIL stress_addr_stable got=%0d changes exp=0", viol); end
    checks++; if (spur !== 0) begin errors++; $display("FAIL stress_spurious_ok got=%0d exp=0", spur); end
    checks++; if (tmo !== 0) begin errors++; $display("FAIL stress_timeout got=%0d exp=0", tmo); end
    checks++; if (a_done < 100 || b_done < 100) begin errors++; $display("FAIL stress_volume got a=%0d b=%0d exp >=100 each", a_done, b_done); end
  endtask

  initial begin
    test_reset();
    test_a_read();
    test_round_robin();
    test_cache_hit();
    test_flush();
    test_flush_fill();
    test_reset_mid();
    test_stress();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
